wrf_udp_tx: RTL and testbench
=============================

WRF_UDP_TX -- requirements
Module: wrf_udp_tx

Interface
REQ-001 Parameter PAYLOAD_WORDS, default 104: number of 16-bit payload words per frame; legal range 1..1024.
REQ-002 Parameter STATUS_WORD, default 16'h0200: value of the WR fabric status word (adr 2'b10).
REQ-003 Parameter TTL, default 8'd63: IPv4 time-to-live.
REQ-004 Port wr_sys_clk  in  1  system clock; all logic is on the rising edge.
REQ-005 Port wr_sys_rst  in  1  reset; one clock, asynchronous, active-high.
REQ-006 Port start  in  1  single-cycle frame request.
REQ-007 Port dst_mac  in  48  destination MAC.
REQ-008 Ports src_ip, dst_ip  in  32 each  IPv4 source and destination addresses.
REQ-009 Ports src_port, dst_port  in  16 each  UDP source and destination ports.
REQ-010 Ports pl_data in 16, pl_valid in 1, pl_ready out 1: payload stream; a word transfers when pl_valid && pl_ready.
REQ-011 Ports wrf_snk_adr out 2, wrf_snk_dat out 16, wrf_snk_cyc out 1, wrf_snk_stb out 1, wrf_snk_we out 1, wrf_snk_sel out 2: pipelined Wishbone master to the WR fabric sink.
REQ-012 Ports wrf_snk_ack, wrf_snk_stall, wrf_snk_err  in  1 each: fabric responses.
REQ-013 Ports busy out 1, frame_done out 1, frame_err out 1: status; done and err are single-cycle pulses.

Function
REQ-014 FSM states: IDLE, CSUM, HDR, PAYLOAD, WAIT_ACK.
REQ-015 In IDLE, start=1 latches dst_mac, src_ip, dst_ip, src_port, dst_port and enters CSUM; start outside IDLE is ignored.
REQ-016 CSUM lasts exactly 12 cycles: 10 accumulations of the ten IPv4 header words (checksum field 0) into a 20-bit sum, then 2 end-around-carry folds; the checksum is the ones-complement of the 16-bit result.
REQ-017 IPv4 header words in order: 16'h4500, total length = 28 + 2*PAYLOAD_WORDS, 16'h0000, 16'h0000, {TTL, 8'h11}, checksum, src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0].
REQ-018 HDR issues 22 words in order: STATUS_WORD, dst_mac[47:32], [31:16], [15:0], three 16'h0000 (source MAC inserted by WR core), 16'h0800, the ten IPv4 words, src_port, dst_port, UDP length = 8 + 2*PAYLOAD_WORDS, 16'h0000.
REQ-019 Word 0 uses wrf_snk_adr=2'b10; all other words use 2'b00; wrf_snk_sel=2'b11 while stb=1, 2'b00 otherwise; wrf_snk_we is constant 1.
REQ-020 A word is accepted in a cycle where stb=1 and stall=0; while stb=1 and stall=1, adr, dat and sel hold stable.
REQ-021 cyc rises with the first stb and stays high continuously until the frame ends.
REQ-022 PAYLOAD issues PAYLOAD_WORDS words from pl_data; pl_ready=1 only in PAYLOAD when the output register is empty or being accepted; if pl_valid=0, stb drops while cyc stays high (no bubble word is sent).
REQ-023 An up/down outstanding counter (11 bits) increments per accepted word and decrements per ack; same-cycle accept and ack leave it unchanged.
REQ-024 After the last payload word is accepted, enter WAIT_ACK with stb=0; when outstanding reaches 0, drop cyc, pulse frame_done, and return to IDLE.
REQ-025 wrf_snk_err=1 while cyc=1 in any state: drop stb and cyc on the next edge, pulse frame_err, discard remaining payload (pl_ready=0), return to IDLE; frame_done does not pulse.
REQ-026 busy=1 in every state except IDLE.
REQ-027 Ack or err while cyc=0 is ignored.

Reset
REQ-028 wr_sys_rst=1 forces, asynchronously, state IDLE, cyc=0, stb=0, sel=2'b00, adr=2'b00, dat=16'h0000, pl_ready=0, busy=0, frame_done=0, frame_err=0, outstanding counter 0.
REQ-029 Reset mid-frame abandons the frame without a done or err pulse; the first start after release begins a complete new frame.

Verification
REQ-030 src_ip 192.168.1.5, dst_ip 192.168.1.122, PAYLOAD_WORDS=104, TTL=63, no stall, ack one cycle after each stb -> 126 words, word 13 = 16'hF731, IPv4 total length 16'd236, UDP length 16'd216, frame_done once.
REQ-031 Same frame, stall held for 5 cycles at word 3 and word 40 -> dat/adr held during the stall, word sequence unchanged, exactly 126 accepts.
REQ-032 pl_valid low for 7 cycles mid-payload -> stb=0 and cyc=1 throughout the gap, no duplicate or missing words.
REQ-033 Acks delayed 4 cycles -> cyc stays high in WAIT_ACK until the 126th ack, then frame_done.
REQ-034 err asserted at word 50 -> cyc=0 next cycle, frame_err pulse, busy=0, a following start sends a full frame.
REQ-035 Reset asserted at word 30, then start -> all outputs at reset values, next frame begins with STATUS_WORD on adr 2'b10.

Source files
------------

// File: rtl/wrf_udp_tx.sv
// UDP/IPv4 frame transmitter feeding the White Rabbit fabric sink.
// Builds the WR status word, Ethernet, IPv4 and UDP headers (with IPv4
// header checksum) and streams the payload over a pipelined Wishbone master.
module wrf_udp_tx #(
  parameter int unsigned PAYLOAD_WORDS = 104,
  parameter logic [15:0] STATUS_WORD   = 16'h0200,
  parameter logic [7:0]  TTL           = 8'd63
) (
  input  logic        wr_sys_clk,
  input  logic        wr_sys_rst,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [15:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [1:0]  wrf_snk_adr,
  output logic [15:0] wrf_snk_dat,
  output logic        wrf_snk_cyc,
  output logic        wrf_snk_stb,
  output logic        wrf_snk_we,
  output logic [1:0]  wrf_snk_sel,
  input  logic        wrf_snk_ack,
  input  logic        wrf_snk_stall,
  input  logic        wrf_snk_err,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HDR,
    PAYLOAD,
    WAIT_ACK
  } state_t;

  localparam logic [15:0] IP_LEN  = 16'(28 + 2 * PAYLOAD_WORDS);
  localparam logic [15:0] UDP_LEN = 16'(8 + 2 * PAYLOAD_WORDS);
  localparam logic [10:0] PL_LAST = 11'(PAYLOAD_WORDS);

  state_t      r_state, w_state_n;
  logic [47:0] r_mac, w_mac_n;
  logic [31:0] r_sip, w_sip_n;
  logic [31:0] r_dip, w_dip_n;
  logic [15:0] r_sport, w_sport_n;
  logic [15:0] r_dport, w_dport_n;
  logic [19:0] r_sum, w_sum_n;
  logic [4:0]  r_cnt, w_cnt_n;
  logic [10:0] r_pl_cnt, w_pl_cnt_n;
  logic [10:0] r_out, w_out_n;
  logic        r_stb, w_stb_n;
  logic        r_cyc, w_cyc_n;
  logic [1:0]  r_adr, w_adr_n;
  logic [15:0] r_dat, w_dat_n;
  logic        r_done, w_done_n;
  logic        r_err, w_err_n;

  logic        w_accept;
  logic        w_ack;
  logic        w_free;
  logic        w_abort;
  logic [4:0]  w_hsel;
  logic [15:0] w_hdr_word;

  assign w_accept = r_stb && !wrf_snk_stall;
  assign w_ack    = r_cyc && wrf_snk_ack;
  assign w_free   = !r_stb || w_accept;
  assign w_abort  = r_cyc && wrf_snk_err;

  // The IPv4 header words are words 8..17 of the frame header, so the checksum
  // pass reads the same table offset by 8, with the checksum slot forced to 0.
  assign w_hsel = (r_state == CSUM) ? (r_cnt + 5'd8) : r_cnt;

  // Header word table indexed by position in the outgoing header
  always_comb begin
    w_hdr_word = '0;
    case (w_hsel)
      5'd0:  w_hdr_word = STATUS_WORD;
      5'd1:  w_hdr_word = r_mac[47:32];
      5'd2:  w_hdr_word = r_mac[31:16];
      5'd3:  w_hdr_word = r_mac[15:0];
      5'd7:  w_hdr_word = 16'h0800;
      5'd8:  w_hdr_word = 16'h4500;
      5'd9:  w_hdr_word = IP_LEN;
      5'd12: w_hdr_word = {TTL, 8'h11};
      5'd13: w_hdr_word = (r_state == CSUM) ? 16'h0000 : ~r_sum[15:0];
      5'd14: w_hdr_word = r_sip[31:16];
      5'd15: w_hdr_word = r_sip[15:0];
      5'd16: w_hdr_word = r_dip[31:16];
      5'd17: w_hdr_word = r_dip[15:0];
      5'd18: w_hdr_word = r_sport;
      5'd19: w_hdr_word = r_dport;
      5'd20: w_hdr_word = UDP_LEN;
      default: w_hdr_word = '0;
    endcase
  end

  // Next-state and next-value logic for the FSM and the bus output register
  always_comb begin
    w_state_n  = r_state;
    w_mac_n    = r_mac;
    w_sip_n    = r_sip;
    w_dip_n    = r_dip;
    w_sport_n  = r_sport;
    w_dport_n  = r_dport;
    w_sum_n    = r_sum;
    w_cnt_n    = r_cnt;
    w_pl_cnt_n = r_pl_cnt;
    w_out_n    = r_out + {10'd0, w_accept} - {10'd0, w_ack};
    w_stb_n    = r_stb;
    w_cyc_n    = r_cyc;
    w_adr_n    = r_adr;
    w_dat_n    = r_dat;
    w_done_n   = 1'b0;
    w_err_n    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_mac_n   = dst_mac;
          w_sip_n   = src_ip;
          w_dip_n   = dst_ip;
          w_sport_n = src_port;
          w_dport_n = dst_port;
          w_sum_n   = '0;
          w_cnt_n   = '0;
          w_state_n = CSUM;
        end
      end
      CSUM: begin
        if (r_cnt < 5'd10) begin
          w_sum_n = r_sum + {4'h0, w_hdr_word};
        end else begin
          w_sum_n = {4'h0, r_sum[15:0]} + {16'h0000, r_sum[19:16]};
        end
        if (r_cnt == 5'd11) begin
          w_cnt_n   = '0;
          w_state_n = HDR;
        end else begin
          w_cnt_n = r_cnt + 5'd1;
        end
      end
      HDR: begin
        if (w_free) begin
          w_stb_n = 1'b1;
          w_cyc_n = 1'b1;
          w_dat_n = w_hdr_word;
          w_adr_n = (r_cnt == 5'd0) ? 2'b10 : 2'b00;
          w_cnt_n = r_cnt + 5'd1;
          if (r_cnt == 5'd21) begin
            w_pl_cnt_n = '0;
            w_state_n  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_free) begin
          if (r_pl_cnt < PL_LAST) begin
            if (pl_valid) begin
              w_stb_n    = 1'b1;
              w_dat_n    = pl_data;
              w_adr_n    = 2'b00;
              w_pl_cnt_n = r_pl_cnt + 11'd1;
            end else begin
              w_stb_n = 1'b0;
            end
          end else begin
            w_stb_n   = 1'b0;
            w_state_n = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (w_out_n == '0) begin
          w_cyc_n   = 1'b0;
          w_adr_n   = '0;
          w_dat_n   = '0;
          w_done_n  = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase

    if (w_abort) begin
      w_stb_n   = 1'b0;
      w_cyc_n   = 1'b0;
      w_adr_n   = '0;
      w_dat_n   = '0;
      w_out_n   = '0;
      w_done_n  = 1'b0;
      w_err_n   = 1'b1;
      w_state_n = IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge wr_sys_clk or posedge wr_sys_rst) begin
    if (wr_sys_rst) begin
      r_state  <= IDLE;
      r_mac    <= '0;
      r_sip    <= '0;
      r_dip    <= '0;
      r_sport  <= '0;
      r_dport  <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_pl_cnt <= '0;
      r_out    <= '0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_mac    <= w_mac_n;
      r_sip    <= w_sip_n;
      r_dip    <= w_dip_n;
      r_sport  <= w_sport_n;
      r_dport  <= w_dport_n;
      r_sum    <= w_sum_n;
      r_cnt    <= w_cnt_n;
      r_pl_cnt <= w_pl_cnt_n;
      r_out    <= w_out_n;
      r_stb    <= w_stb_n;
      r_cyc    <= w_cyc_n;
      r_adr    <= w_adr_n;
      r_dat    <= w_dat_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
    end
  end

  assign pl_ready    = (r_state == PAYLOAD) && (r_pl_cnt < PL_LAST) && w_free && !w_abort;
  assign wrf_snk_adr = r_adr;
  assign wrf_snk_dat = r_dat;
  assign wrf_snk_cyc = r_cyc;
  assign wrf_snk_stb = r_stb;
  assign wrf_snk_we  = 1'b1;
  assign wrf_snk_sel = r_stb ? 2'b11 : 2'b00;
  assign busy        = (r_state != IDLE);
  assign frame_done  = r_done;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_wrf_udp_tx.sv
// Bench for wrf_udp_tx: table of frame scenarios plus hand-written error and
// reset sequences; a scoreboard queue holds every expected bus word.
module tb_wrf_udp_tx;

  localparam int PW = 104;

  logic        wr_sys_clk, wr_sys_rst, start;
  logic [47:0] dst_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, pl_data;
  logic        pl_valid, pl_ready;
  logic [1:0]  wrf_snk_adr, wrf_snk_sel;
  logic [15:0] wrf_snk_dat;
  logic        wrf_snk_cyc, wrf_snk_stb, wrf_snk_we;
  logic        wrf_snk_ack, wrf_snk_stall, wrf_snk_err;
  logic        busy, frame_done, frame_err;

  wrf_udp_tx #(
    .PAYLOAD_WORDS(104),
    .STATUS_WORD  (16'h0200),
    .TTL          (8'd63)
  ) dut (
    .wr_sys_clk   (wr_sys_clk),
    .wr_sys_rst   (wr_sys_rst),
    .start        (start),
    .dst_mac      (dst_mac),
    .src_ip       (src_ip),
    .dst_ip       (dst_ip),
    .src_port     (src_port),
    .dst_port     (dst_port),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .wrf_snk_adr  (wrf_snk_adr),
    .wrf_snk_dat  (wrf_snk_dat),
    .wrf_snk_cyc  (wrf_snk_cyc),
    .wrf_snk_stb  (wrf_snk_stb),
    .wrf_snk_we   (wrf_snk_we),
    .wrf_snk_sel  (wrf_snk_sel),
    .wrf_snk_ack  (wrf_snk_ack),
    .wrf_snk_stall(wrf_snk_stall),
    .wrf_snk_err  (wrf_snk_err),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [47:0] mac;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sport;
    logic [15:0] dport;
    int          stall_a;
    int          stall_b;
    int          stall_len;
    int          gap_at;
    int          gap_len;
    int          err_at;
    int          restart_at;
    int          ack_dly;
    logic [15:0] exp_csum;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int failures = 0;

  // scenario configuration read by the bus responder
  int cfg_stall_a = -1, cfg_stall_b = -1, cfg_stall_len = 0;
  int cfg_gap_at = -1, cfg_gap_len = 0, cfg_err_at = -1, cfg_ack_dly = 1;

  // bookkeeping
  int          cyc_n = 0;
  int          n_acc = 0, n_ack = 0, n_done = 0, n_err = 0, pl_idx = 0, cyc_breaks = 0;
  logic [15:0] cap[0:127];
  logic [17:0] exp_q[$];
  int          ack_q[$];
  bit          stall_a_done = 0, stall_b_done = 0, gap_done = 0, err_done = 0;
  int          stall_left = 0, gap_left = 0, gap_n = 0;
  bit          stray_ack_req = 0, stray_err_req = 0;
  int          err_drive_cyc = 0, err_seen_cyc = 0;
  logic        err_cyc_v = 1'b1, err_busy_v = 1'b1, err_rdy_v = 1'b1;
  logic [7:0]  pl_tag = 8'h00;

  initial begin
    wr_sys_clk = 1'b0;
    forever #5 wr_sys_clk = ~wr_sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge wr_sys_clk);
    #2;
  endtask

  // Bus responder and monitor: drives stall/ack/err/payload at the falling
  // edge, samples everything 1 ns before the rising edge.
  initial begin : monitor
    logic        p_stb, p_stall, p_cyc;
    logic [15:0] p_dat;
    logic [1:0]  p_adr;
    logic [17:0] e;
    p_stb = 1'b0; p_stall = 1'b0; p_cyc = 1'b0; p_dat = '0; p_adr = '0;
    forever begin
      @(negedge wr_sys_clk);
      if (!stall_a_done && cfg_stall_a >= 0 && n_acc == cfg_stall_a) begin
        stall_left = cfg_stall_len; stall_a_done = 1;
      end else if (!stall_b_done && cfg_stall_b >= 0 && n_acc == cfg_stall_b) begin
        stall_left = cfg_stall_len; stall_b_done = 1;
      end
      if (stall_left > 0) begin
        wrf_snk_stall = 1'b1; stall_left--;
      end else begin
        wrf_snk_stall = 1'b0;
      end
      if (!gap_done && cfg_gap_at >= 0 && pl_idx == cfg_gap_at) begin
        gap_left = cfg_gap_len; gap_done = 1; gap_n = 0;
      end
      if (gap_left > 0) begin
        pl_valid = 1'b0; gap_left--; gap_n++;
      end else begin
        gap_n = 0;
        pl_valid = (pl_idx < PW);
      end
      pl_data = {pl_tag, 8'(pl_idx)};
      wrf_snk_ack = 1'b0;
      if (ack_q.size() > 0 && ack_q[0] <= cyc_n) begin
        wrf_snk_ack = 1'b1; void'(ack_q.pop_front());
      end else if (stray_ack_req) begin
        wrf_snk_ack = 1'b1; stray_ack_req = 0;
      end
      wrf_snk_err = 1'b0;
      if (!err_done && cfg_err_at >= 0 && n_acc == cfg_err_at) begin
        wrf_snk_err = 1'b1; err_done = 1; err_drive_cyc = cyc_n;
      end else if (stray_err_req) begin
        wrf_snk_err = 1'b1; stray_err_req = 0;
      end

      #4;
      if (p_stb && p_stall && wrf_snk_stb) begin
        chk("stall_hold", {14'd0, wrf_snk_adr, wrf_snk_dat}, {14'd0, p_adr, p_dat});
      end
      if (wrf_snk_stb && !wrf_snk_stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_word actual=%h required=none", wrf_snk_dat);
        end else begin
          e = exp_q.pop_front();
          if ({wrf_snk_adr, wrf_snk_dat, wrf_snk_sel, wrf_snk_cyc, wrf_snk_we} !== {e, 2'b11, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL word%0d actual=%h/%h sel=%b cyc=%b we=%b required=%h/%h sel=11 cyc=1 we=1",
                     n_acc, wrf_snk_adr, wrf_snk_dat, wrf_snk_sel, wrf_snk_cyc, wrf_snk_we, e[17:16], e[15:0]);
          end
        end
        if (n_acc < 128) cap[n_acc] = wrf_snk_dat;
        n_acc++;
        ack_q.push_back(cyc_n + cfg_ack_dly);
      end
      if (wrf_snk_ack && wrf_snk_cyc) n_ack++;
      if (gap_n >= 2) begin
        chk("gap_bus", {30'd0, wrf_snk_stb, wrf_snk_cyc}, 32'b01);
      end
      if (pl_valid && pl_ready) pl_idx++;
      if (p_cyc && !wrf_snk_cyc && !frame_done && !frame_err && !wr_sys_rst) cyc_breaks++;
      if (frame_done) n_done++;
      if (frame_err) begin
        n_err++;
        err_seen_cyc = cyc_n;
        err_cyc_v = wrf_snk_cyc;
        err_busy_v = busy;
        err_rdy_v = pl_ready;
      end
      p_stb = wrf_snk_stb; p_stall = wrf_snk_stall; p_cyc = wrf_snk_cyc;
      p_dat = wrf_snk_dat; p_adr = wrf_snk_adr;
      cyc_n++;
    end
  end

  task automatic load_frame(input vec_t v, input logic [7:0] tag);
    exp_q.delete();
    ack_q.delete();
    n_acc = 0; n_ack = 0; n_done = 0; n_err = 0; pl_idx = 0; cyc_breaks = 0;
    stall_a_done = 0; stall_b_done = 0; gap_done = 0; err_done = 0;
    stall_left = 0; gap_left = 0;
    for (int i = 0; i < 128; i++) cap[i] = 16'hDEAD;
    pl_tag = tag;
    cfg_stall_a = v.stall_a; cfg_stall_b = v.stall_b; cfg_stall_len = v.stall_len;
    cfg_gap_at = v.gap_at; cfg_gap_len = v.gap_len; cfg_err_at = v.err_at;
    cfg_ack_dly = v.ack_dly;
    exp_q.push_back({2'b10, 16'h0200});
    exp_q.push_back({2'b00, v.mac[47:32]});
    exp_q.push_back({2'b00, v.mac[31:16]});
    exp_q.push_back({2'b00, v.mac[15:0]});
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 16'h0000});
    exp_q.push_back({2'b00, 16'h0800});
    exp_q.push_back({2'b00, 16'h4500});
    exp_q.push_back({2'b00, 16'd236});
    exp_q.push_back({2'b00, 16'h0000});
    exp_q.push_back({2'b00, 16'h0000});
    exp_q.push_back({2'b00, 16'h3F11});
    exp_q.push_back({2'b00, v.exp_csum});
    exp_q.push_back({2'b00, v.sip[31:16]});
    exp_q.push_back({2'b00, v.sip[15:0]});
    exp_q.push_back({2'b00, v.dip[31:16]});
    exp_q.push_back({2'b00, v.dip[15:0]});
    exp_q.push_back({2'b00, v.sport});
    exp_q.push_back({2'b00, v.dport});
    exp_q.push_back({2'b00, 16'd216});
    exp_q.push_back({2'b00, 16'h0000});
    for (int i = 0; i < PW; i++) exp_q.push_back({2'b00, tag, 8'(i)});
  endtask

  task automatic pulse_start(input vec_t v);
    dst_mac = v.mac; src_ip = v.sip; dst_ip = v.dip;
    src_port = v.sport; dst_port = v.dport;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input logic [7:0] tag);
    bit restarted;
    restarted = 0;
    load_frame(v, tag);
    pulse_start(v);
    for (int c = 0; c < 3000 && n_done == 0 && n_err == 0; c++) begin
      if (v.restart_at >= 0 && n_acc >= v.restart_at && !restarted) begin
        dst_mac = ~v.mac; src_ip = ~v.sip; dst_ip = ~v.dip;
        start = 1'b1; restarted = 1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    if (n_done == 0 && n_err == 0) begin
      checks++; failures++;
      $display("FAIL frame_timeout actual=no_done required=done");
    end
    repeat (4) step();
    chk("accepts", n_acc, 126);
    chk("acks_before_done", n_ack, 126);
    chk("done_pulses", n_done, 1);
    chk("err_pulses", n_err, 0);
    chk("sb_left", exp_q.size(), 0);
    chk("status_word", cap[0], 16'h0200);
    chk("ip_total_len", cap[9], 16'd236);
    chk("ip_checksum", cap[13], v.exp_csum);
    chk("udp_len", cap[20], 16'd216);
    chk("cyc_breaks", cyc_breaks, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cyc", wrf_snk_cyc, 0);
  endtask

  initial begin : main
    vec_t ve;
    vecs[0] = '{48'h0050_C2AB_CDEF, 32'hC0A8_0105, 32'hC0A8_017A, 16'd5000, 16'd6000,
                -1, -1, 0, -1, 0, -1, -1, 1, 16'hF731};
    vecs[1] = '{48'h0050_C2AB_CDEF, 32'hC0A8_0105, 32'hC0A8_017A, 16'd5000, 16'd6000,
                3, 40, 5, -1, 0, -1, -1, 1, 16'hF731};
    vecs[2] = '{48'h0011_2233_4455, 32'h0A00_0001, 32'h0A00_0002, 16'd1234, 16'd80,
                -1, -1, 0, 50, 7, -1, 60, 1, 16'h66FF};
    vecs[3] = '{48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'h0001,
                -1, -1, 0, -1, 0, -1, -1, 4, 16'h7B02};
    vecs[4] = '{48'h0200_0000_0001, 32'hAC10_0001, 32'hC0A8_0001, 16'd319, 16'd320,
                21, -1, 3, 1, 3, -1, -1, 2, 16'h0E47};

    wr_sys_rst = 1'b0; start = 1'b0; dst_mac = '0; src_ip = '0; dst_ip = '0;
    src_port = '0; dst_port = '0; pl_data = '0; pl_valid = 1'b0;
    wrf_snk_ack = 1'b0; wrf_snk_stall = 1'b0; wrf_snk_err = 1'b0;
    #3 wr_sys_rst = 1'b1;
    #1;
    chk("reset_bus", {wrf_snk_cyc, wrf_snk_stb, wrf_snk_sel, wrf_snk_adr, wrf_snk_dat}, 0);
    chk("reset_status", {pl_ready, busy, frame_done, frame_err}, 0);
    repeat (2) step();
    wr_sys_rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 5; i++) run_frame(vecs[i], 8'(8'h10 + i));

    // error abort at word 50, then stray ack/err while idle
    ve = vecs[0];
    ve.err_at = 50;
    load_frame(ve, 8'h3C);
    pulse_start(ve);
    for (int c = 0; c < 3000 && n_err == 0; c++) step();
    repeat (3) step();
    chk("err_pulses", n_err, 1);
    chk("err_latency", err_seen_cyc - err_drive_cyc, 1);
    chk("err_cyc_low", err_cyc_v, 0);
    chk("err_busy_low", err_busy_v, 0);
    chk("err_pl_ready_low", err_rdy_v, 0);
    chk("err_no_done", n_done, 0);
    stray_ack_req = 1;
    step();
    stray_err_req = 1;
    repeat (3) step();
    chk("stray_err_ignored", n_err, 1);
    chk("stray_busy", busy, 0);
    run_frame(vecs[0], 8'h4D);

    // reset in the middle of a frame
    load_frame(vecs[0], 8'h5A);
    pulse_start(vecs[0]);
    for (int c = 0; c < 500 && n_acc < 30; c++) step();
    chk("reached_word30", (n_acc >= 30) ? 32'd1 : 32'd0, 1);
    wr_sys_rst = 1'b1;
    #1;
    chk("midrst_bus", {wrf_snk_cyc, wrf_snk_stb, wrf_snk_sel, wrf_snk_adr, wrf_snk_dat}, 0);
    chk("midrst_status", {pl_ready, busy, frame_done, frame_err}, 0);
    step();
    wr_sys_rst = 1'b0;
    repeat (3) step();
    chk("midrst_no_done", n_done, 0);
    chk("midrst_no_err", n_err, 0);
    run_frame(vecs[0], 8'h6B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
